// File: rtl/resp_check_pkg.sv
// resp_check_pkg: shared state encoding, MISR defaults and the word-folding helper
package resp_check_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;
  localparam int FOLD_CHUNK_W = 32;
  localparam int FOLD_MAX_W = 1024;
  // Callers zero-extend to FOLD_MAX_W, which also zero-pads the top partial chunk
  function automatic logic [FOLD_CHUNK_W-1:0] fold_word(input logic [FOLD_MAX_W-1:0] w);
    logic [FOLD_CHUNK_W-1:0] f;
    f = '0;
    for (int i = 0; i < FOLD_MAX_W / FOLD_CHUNK_W; i++) f ^= w[i*FOLD_CHUNK_W +: FOLD_CHUNK_W];
    return f;
  endfunction
endpackage

// File: rtl/vector_response_checker_if.sv
// vector_response_checker_if: DUT-output bus plus run control/status of the checker
interface vector_response_checker_if #(
  parameter int DATA_W = 605,
  parameter int SIG_W  = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [CNT_W-1:0]  num_vec;
  logic [SIG_W-1:0]  exp_sig;
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              busy;
  logic              done;
  logic              pass;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  vec_count;
  modport master (output start, num_vec, exp_sig, y, y_valid,
                  input busy, done, pass, signature, vec_count);
  modport slave (input start, num_vec, exp_sig, y, y_valid,
                 output busy, done, pass, signature, vec_count);
endinterface

// File: rtl/misr_step.sv
// misr_step: folds one output word and advances the Galois MISR by one step
module misr_step import resp_check_pkg::*; #(
  parameter int DATA_W = 605,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = DEF_POLY
) (
  input  logic [SIG_W-1:0]  i_sig,
  input  logic [DATA_W-1:0] i_y,
  output logic [SIG_W-1:0]  o_sig_next
);
  logic [SIG_W-1:0] w_f;
  always_comb begin
    w_f = fold_word(FOLD_MAX_W'(i_y));
    o_sig_next = {i_sig[SIG_W-2:0], 1'b0} ^ (i_sig[SIG_W-1] ? POLY : '0) ^ w_f;
  end
endmodule

// File: rtl/vector_response_checker.sv
// vector_response_checker: compacts valid DUT words into a MISR and compares after num_vec vectors
module vector_response_checker import resp_check_pkg::*; #(
  parameter int DATA_W = 605,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED = DEF_SEED,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  vector_response_checker_if.slave bus
);
  state_t r_state, w_next;
  logic [SIG_W-1:0] r_sig, r_exp, w_sig_next;
  logic [CNT_W-1:0] r_cnt, r_num, w_cnt_inc;
  logic r_done, r_pass, w_load, w_step;

  misr_step #(.DATA_W(DATA_W), .SIG_W(SIG_W), .POLY(POLY)) u_step (
    .i_sig(r_sig), .i_y(bus.y), .o_sig_next(w_sig_next)
  );

  assign w_load = r_state == IDLE && bus.start;
  assign w_step = r_state == RUN && bus.y_valid;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_next = r_state;
    if (w_load) w_next = (bus.num_vec != '0) ? RUN : CHECK;
    else if (w_step && w_cnt_inc == r_num) w_next = CHECK;
    else if (r_state == CHECK) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sig <= SEED;
      r_cnt <= '0;
      r_num <= '0;
      r_exp <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= r_state == CHECK;
      if (w_load) begin
        r_sig <= SEED;
        r_cnt <= '0;
        r_num <= bus.num_vec;
        r_exp <= bus.exp_sig;
        r_pass <= 1'b0;
      end
      if (w_step) begin
        r_sig <= w_sig_next;
        r_cnt <= w_cnt_inc;
      end
      if (r_state == CHECK) r_pass <= r_sig == r_exp;
    end

  assign bus.busy = r_state != IDLE;
  assign bus.done = r_done;
  assign bus.pass = r_pass;
  assign bus.signature = r_sig;
  assign bus.vec_count = r_cnt;
endmodule

// File: doc/vector_response_checker.md
# vector_response_checker

Synthesizable output-side counterpart to the stimulus driver in our equivalence/simulation benches. It samples the DUT result word `y` once per valid cycle and compacts it into a 32-bit multiple-input signature register (MISR). After a programmed number of vectors it compares the signature against an expected value and reports pass/fail. It sits directly on the DUT output bus and replaces per-cycle `$strobe` dumps with a single comparable signature, usable both in simulation and on silicon/FPGA.

## Interface
- `DATA_W`, 605: width of the DUT output word `y` (bits 604..0).
- `SIG_W`, 32: signature width.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial (Galois form).
- `SEED`, 32'hFFFFFFFF: signature value loaded on start and on reset.
- `CNT_W`, 16: width of the vector counter.

- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `num_vec`  in  CNT_W  vectors to compact; sampled with `start`.
- `exp_sig`  in  SIG_W  expected signature; sampled with `start`.
- `y`  in  DATA_W  DUT output word.
- `y_valid`  in  1  `y` is a vector to compact this cycle.
- `busy`  out  1  high in RUN and CHECK.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  result of last compare; held until next `start`.
- `signature`  out  SIG_W  live MISR value.
- `vec_count`  out  CNT_W  vectors compacted in current/last run.

## Operation
- Fold: split `y` into ceil(DATA_W/SIG_W) = 19 chunks of SIG_W, LSB chunk first, top chunk zero-padded; XOR all chunks → `f`.
- MISR step: `sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ f`.
- FSM states: IDLE, RUN, CHECK.
  - IDLE: on `start`: sig←SEED, vec_count←0, latch `num_vec`/`exp_sig`, pass←0; go to RUN if num_vec≠0, else CHECK.
  - RUN: each cycle with `y_valid`: sig←sig_next, vec_count+1. When vec_count+1 == latched num_vec, go to CHECK on the same edge. `y_valid` low: hold.
  - CHECK: one cycle. On exit: done←1, pass←(sig == latched exp_sig), go to IDLE.
- `start` in RUN/CHECK is ignored. `y_valid` outside RUN is ignored.
- vec_count does not wrap within a run; num_vec max 2^CNT_W−1.

## Timing
- Reset (async assert, sync release): state IDLE, signature=SEED, vec_count=0, busy=0, done=0, pass=0.
- `busy` rises the cycle after `start` is sampled.
- The last valid vector is sampled at edge E. The MISR update and entry to CHECK happen at E. `done` and `pass` are set at E+1. `busy` falls at E+1. `done` clears at E+2.
- num_vec=0: `start` at edge S → CHECK at S → `done` at S+1, signature=SEED.
- `start` and `y_valid` in the same IDLE cycle: `y` is not compacted.
- Reset mid-run: aborts immediately to reset values; no `done`.

## Structure
- Package `resp_check_pkg`:
  - state enum (IDLE/RUN/CHECK);
  - default POLY/SEED constants;
  - `fold_word` function (parameterized chunk XOR).
- Sub-module `misr_step`: combinational `sig`, `f` → `sig_next`. Keeps the folding/feedback separately unit-testable.
- Top-level: FSM, counters, latches.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle → signature=32'hFFFFFFFF, busy/done/pass=0 immediately.
- Single zero vector: num_vec=1, y=0, exp_sig=32'hFB3EE249 → signature=32'hFB3EE249, done pulse at E+1, pass=1, vec_count=1.
- Empty run: num_vec=0, exp_sig=32'hFFFFFFFF → done exactly 1 cycle after the start edge, pass=1. Repeat with exp_sig=0 → pass=0.
- Gapped stream: num_vec=20, drive the 20 bench stimulus-derived `y` words with `y_valid` toggled 1-0-1 → signature equals the software MISR model, and equals the gapless run; busy high throughout.
- Fault sensitivity: same 20 vectors with bit 604 of vector 7 flipped → signature differs, pass=0.
- Robustness: `start` asserted during RUN → ignored, count unaffected. Reset at vector 10 → no done pulse; a new run then starts from SEED.
